// File: rtl/posit_round_pack_pipe.sv
// Two-stage posit encoder/rounder: S1 builds the unrounded regime/exp/frac string,
// S2 rounds, saturates to [minpos, maxpos] and applies the sign.
module posit_round_pack_pipe #(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 2,
    parameter int unsigned FW = N,
    parameter int unsigned KW = $clog2(N) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [KW-1:0] in_k,
    input  logic [ES-1:0]        in_exp,
    input  logic [FW-1:0]        in_frac,
    input  logic                 in_sticky,
    input  logic                 in_zero,
    input  logic                 in_nar,
    input  logic [1:0]           rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit,
    output logic                 out_inexact
);

    localparam int unsigned M = N + ES + FW;
    localparam logic signed [KW-1:0] KMax = KW'(N - 2);
    localparam logic signed [KW-1:0] KMin = -KMax;

    localparam logic [1:0] RndRne = 2'b00;
    localparam logic [1:0] RndRtz = 2'b01;
    localparam logic [1:0] RndRup = 2'b10;

    logic s2_load;

    // S1 state
    logic         v1_q, v1_d;
    logic [N-2:0] mag1_q, mag1_d;
    logic         g1_q, g1_d;
    logic         s1_q, s1_d;
    logic         sign1_q, sign1_d;
    logic [1:0]   mode1_q, mode1_d;
    logic         zero1_q, zero1_d;
    logic         nar1_q, nar1_d;
    logic         chi1_q, chi1_d;
    logic         clo1_q, clo1_d;

    // S2 state
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_posit_q, out_posit_d;
    logic         out_inexact_q, out_inexact_d;

    // S1 build datapath
    logic                 clamp_hi, clamp_lo;
    logic signed [KW-1:0] k_c;
    logic [KW-1:0]        run_len;
    logic [KW-1:0]        shamt;
    logic [M-1:0]         build;
    logic [M-1:0]         aligned;

    always_comb begin
        clamp_hi = in_k > KMax;
        clamp_lo = in_k < KMin;
        if (clamp_hi) begin
            k_c = KMax;
        end else if (clamp_lo) begin
            k_c = KMin;
        end else begin
            k_c = in_k;
        end
        // k>=0 gives k+1 ones, k<0 gives -k zeros; the terminator is the opposite bit
        if (k_c[KW-1]) begin
            run_len = ~k_c + KW'(1);
        end else begin
            run_len = k_c + KW'(1);
        end
        shamt   = KW'(N - 1) - run_len;
        build   = {{(N-1){~k_c[KW-1]}}, k_c[KW-1], in_exp, in_frac};
        // Drop surplus run bits off the top so the string starts just below the sign
        aligned = build << shamt;
    end

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !v1_q || s2_load;

    always_comb begin
        v1_d    = v1_q;
        mag1_d  = mag1_q;
        g1_d    = g1_q;
        s1_d    = s1_q;
        sign1_d = sign1_q;
        mode1_d = mode1_q;
        zero1_d = zero1_q;
        nar1_d  = nar1_q;
        chi1_d  = chi1_q;
        clo1_d  = clo1_q;
        if (in_ready) begin
            v1_d = in_valid;
        end
        if (in_valid && in_ready) begin
            mag1_d  = aligned[M-1 -: N-1];
            g1_d    = aligned[M-N];
            s1_d    = (|aligned[M-N-1:0]) | in_sticky;
            sign1_d = in_sign;
            mode1_d = rnd_mode;
            zero1_d = in_zero;
            nar1_d  = in_nar;
            chi1_d  = clamp_hi;
            clo1_d  = clamp_lo;
        end
    end

    // S2 round / saturate / sign datapath
    logic         inc;
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic [N-1:0] posit;
    logic         inexact;

    always_comb begin
        case (mode1_q)
            RndRne:  inc = g1_q & (mag1_q[0] | s1_q);
            RndRtz:  inc = 1'b0;
            RndRup:  inc = !sign1_q & (g1_q | s1_q);
            default: inc = sign1_q & (g1_q | s1_q);
        endcase
        sum = {1'b0, mag1_q} + N'(inc);
        // Nonzero results never round to 0 or overflow into NaR
        if (sum[N-1] || chi1_q) begin
            mag = '1;
        end else if (sum[N-2:0] == '0 || clo1_q) begin
            mag = {{(N-2){1'b0}}, 1'b1};
        end else begin
            mag = sum[N-2:0];
        end
        if (sign1_q) begin
            posit = ~{1'b0, mag} + N'(1);
        end else begin
            posit = {1'b0, mag};
        end
        inexact = g1_q | s1_q | chi1_q | clo1_q;
        if (nar1_q) begin
            posit   = {1'b1, {(N-1){1'b0}}};
            inexact = 1'b0;
        end else if (zero1_q) begin
            posit   = '0;
            inexact = 1'b0;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_posit_d   = out_posit_q;
        out_inexact_d = out_inexact_q;
        if (s2_load) begin
            out_valid_d = v1_q;
            if (v1_q) begin
                out_posit_d   = posit;
                out_inexact_d = inexact;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q          <= 1'b0;
            mag1_q        <= '0;
            g1_q          <= 1'b0;
            s1_q          <= 1'b0;
            sign1_q       <= 1'b0;
            mode1_q       <= 2'b00;
            zero1_q       <= 1'b0;
            nar1_q        <= 1'b0;
            chi1_q        <= 1'b0;
            clo1_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_posit_q   <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            mag1_q        <= mag1_d;
            g1_q          <= g1_d;
            s1_q          <= s1_d;
            sign1_q       <= sign1_d;
            mode1_q       <= mode1_d;
            zero1_q       <= zero1_d;
            nar1_q        <= nar1_d;
            chi1_q        <= chi1_d;
            clo1_q        <= clo1_d;
            out_valid_q   <= out_valid_d;
            out_posit_q   <= out_posit_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_posit   = out_posit_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_posit_round_pack_pipe.sv
// Scoreboard bench for posit_round_pack_pipe (N=16, ES=1): directed vectors, random
// traffic against a bit-string reference model, stalls and mid-stream reset.
module tb_posit_round_pack_pipe;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int FW = 16;
    localparam int KW = 6;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic signed [KW-1:0] in_k;
    logic [ES-1:0]        in_exp;
    logic [FW-1:0]        in_frac;
    logic                 in_sticky;
    logic                 in_zero;
    logic                 in_nar;
    logic [1:0]           rnd_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_posit;
    logic                 out_inexact;

    posit_round_pack_pipe #(.N(N), .ES(ES), .FW(FW), .KW(KW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_k       (in_k),
        .in_exp     (in_exp),
        .in_frac    (in_frac),
        .in_sticky  (in_sticky),
        .in_zero    (in_zero),
        .in_nar     (in_nar),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit),
        .out_inexact(out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [N:0] exp_q[$];
    bit rdy_rand = 1'b0;
    bit stalled = 1'b0;
    logic [N-1:0] stall_posit;
    logic stall_inex;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: spell out the posit bit string, keep N-1 bits, round, saturate, negate
    function automatic logic [N:0] model(input bit sign, input int k, input int ex, input int frac,
                                         input bit sticky, input bit zero, input bit nar,
                                         input int mode);
        bit q[$];
        int kc, mag, inc, sum, maxpos, posit;
        bit chi, clo, g, s;
        if (nar) return {1'b0, 1'b1, {(N-1){1'b0}}};
        if (zero) return '0;
        chi = k > N - 2;
        clo = k < -(N - 2);
        kc = chi ? N - 2 : (clo ? -(N - 2) : k);
        if (kc >= 0) begin
            for (int i = 0; i < kc + 1; i++) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            for (int i = 0; i < -kc; i++) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        for (int i = ES - 1; i >= 0; i--) q.push_back(bit'((ex >> i) & 1));
        for (int i = FW - 1; i >= 0; i--) q.push_back(bit'((frac >> i) & 1));
        mag = 0;
        for (int i = 0; i < N - 1; i++) mag = mag * 2 + int'(q[i]);
        g = q[N-1];
        s = sticky;
        for (int i = N; i < q.size(); i++) s = s | q[i];
        case (mode)
            0:       inc = int'(g && ((mag % 2 == 1) || s));
            1:       inc = 0;
            2:       inc = int'(!sign && (g || s));
            default: inc = int'(sign && (g || s));
        endcase
        maxpos = (1 << (N - 1)) - 1;
        sum = mag + inc;
        if (sum > maxpos || chi) sum = maxpos;
        else if (sum == 0 || clo) sum = 1;
        posit = sign ? ((1 << N) - sum) : sum;
        posit = posit & ((1 << N) - 1);
        return {g | s | chi | clo, N'(posit)};
    endfunction

    task automatic issue(input bit sign, input int k, input int ex, input int frac, input bit sticky,
                         input bit zero, input bit nar, input int mode,
                         input bit directed, input logic [N:0] dexp);
        int n = 0;
        bit ok = 1'b0;
        in_sign = sign; in_k = KW'(k); in_exp = ES'(ex); in_frac = FW'(frac);
        in_sticky = sticky; in_zero = zero; in_nar = nar; rnd_mode = 2'(mode);
        in_valid = 1'b1;
        while (!ok && n <= 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, expected accept", n);
        end else begin
            exp_q.push_back(directed ? dexp : model(sign, k, ex, frac, sticky, zero, nar, mode));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic dir(input bit sign, input int k, input int ex, input int frac, input bit sticky,
                       input int mode, input logic [N-1:0] p, input bit inex);
        issue(sign, k, ex, frac, sticky, 1'b0, 1'b0, mode, 1'b1, {inex, p});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per output transfer, checks hold stability
    always @(negedge clk) begin
        logic [N:0] e;
        if (rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_posit", 32'(out_posit), 32'(stall_posit));
                chk("hold_inexact", 32'(out_inexact), 32'(stall_inex));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got posit %0h, expected no output", out_posit);
                end else begin
                    e = exp_q.pop_front();
                    chk("posit", 32'(out_posit), 32'(e[N-1:0]));
                    chk("inexact", 32'(out_inexact), 32'(e[N]));
                end
            end
            stalled = out_valid && !out_ready;
            stall_posit = out_posit;
            stall_inex = out_inexact;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_k = '0; in_exp = '0; in_frac = '0;
        in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0; rnd_mode = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_posit", 32'(out_posit), 32'd0);
        chk("reset_out_inexact", 32'(out_inexact), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        dir(0, 0, 0, 'h0000, 0, 0, 16'h4000, 0);
        dir(1, 0, 0, 'h0000, 0, 0, 16'hC000, 0);
        dir(0, 0, 0, 'h0008, 0, 0, 16'h4000, 1);
        dir(0, 0, 0, 'h0018, 0, 0, 16'h4002, 1);
        dir(0, 0, 0, 'h0008, 1, 0, 16'h4001, 1);
        dir(0, 0, 0, 'h0001, 0, 1, 16'h4000, 1);
        dir(0, 0, 0, 'h0001, 0, 2, 16'h4001, 1);
        dir(0, 0, 0, 'h0001, 0, 3, 16'h4000, 1);
        dir(1, 0, 0, 'h0001, 0, 3, 16'hBFFF, 1);
        dir(0, 0, 1, 'hFFF8, 0, 0, 16'h6000, 1);
        dir(0, 15, 0, 'h0000, 0, 0, 16'h7FFF, 1);
        dir(0, -20, 0, 'h0000, 0, 1, 16'h0001, 1);
        dir(0, 14, 1, 'hFFFF, 0, 0, 16'h7FFF, 1);
        dir(0, 14, 1, 'hFFFF, 0, 2, 16'h7FFF, 1);
        dir(1, -20, 0, 'h0000, 0, 3, 16'hFFFF, 1);
        dir(0, -14, 0, 'h0000, 0, 0, 16'h0001, 0);
        dir(0, -1, 0, 'h0000, 0, 0, 16'h2000, 0);
        issue(0, 0, 0, 'h1234, 1, 0, 1, 2, 1'b1, 17'h08000);
        issue(1, 3, 1, 'h5678, 1, 1, 0, 2, 1'b1, 17'h00000);
        issue(0, 0, 0, 0, 0, 1, 1, 0, 1'b1, 17'h08000);
        drain();

        // Back-to-back issue into a stalled output
        out_ready = 1'b0;
        fork
            begin
                dir(0, 0, 0, 'h0000, 0, 0, 16'h4000, 0);
                dir(1, 0, 0, 'h0000, 0, 0, 16'hC000, 0);
                issue(0, 2, 1, 'h0F0F, 0, 0, 1, 0, 1'b1, 17'h08000);
                issue(1, 2, 1, 'h0F0F, 0, 1, 0, 0, 1'b1, 17'h00000);
                dir(0, 1, 0, 'h0000, 0, 0, 16'h6000, 0);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("in_ready_stall", 32'(in_ready), 32'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Mid-stream reset discards in-flight work
        out_ready = 1'b0;
        dir(0, 0, 0, 'h0000, 0, 0, 16'h4000, 0);
        dir(0, 1, 0, 'h0000, 0, 0, 16'h6000, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_posit", 32'(out_posit), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        dir(1, 1, 0, 'h0000, 0, 0, 16'hA000, 0);
        drain();

        // Random traffic with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 40) - 20, $urandom_range(0, 1),
                  $urandom_range(0, 65535), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                  $urandom_range(0, 3), 1'b0, '0);
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
